// File: rtl/button_debounce_fsm.sv
// rtl/button_debounce_fsm.sv - push-button debounce FSM driving an external interval timer
// Optional auto-repeat while held is built when DEBOUNCE_REPEAT_EN is defined.
module button_debounce_fsm #(
    parameter int REPEAT_DELAY = 63,
    parameter int REPEAT_RATE  = 13
) (
    input  logic clk,
    input  logic rst,
    input  logic btnIn,
    input  logic timerOut,
    output logic timerControl,
    output logic btnLevel,
    output logic btnPulse
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_PRESS,
        HELD,
        WAIT_RELEASE
    } state_t;

    state_t r_state;
    logic   r_s1;
    logic   r_s2;
    logic   r_timer_ctrl;
    logic   r_level;
    logic   r_pulse;

    generate
        if (REPEAT_DELAY < 0 || REPEAT_DELAY > 255 || REPEAT_RATE < 0 || REPEAT_RATE > 255) begin : g_param_check
            $error("repeat parameters must fit the 8-bit expiry counter");
        end
    endgenerate

`ifdef DEBOUNCE_REPEAT_EN
    localparam logic [7:0] DELAY_EFF = (REPEAT_DELAY == 0) ? 8'd1 : 8'(REPEAT_DELAY);
    localparam logic [7:0] RATE_EFF  = (REPEAT_RATE == 0)  ? 8'd1 : 8'(REPEAT_RATE);

    logic [7:0] r_rpt_cnt;
    logic       r_first;
    logic       w_expiry;
    logic [7:0] w_cnt_next;
    logic [7:0] w_target;

    // Only count expiries while the timer is really running; this masks a stale
    // timerOut left over from a WAIT_RELEASE bounce back into HELD.
    assign w_expiry   = timerOut & r_timer_ctrl;
    assign w_cnt_next = r_rpt_cnt + 8'd1;
    assign w_target   = r_first ? RATE_EFF : DELAY_EFF;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_s1         <= 1'b0;
            r_s2         <= 1'b0;
            r_timer_ctrl <= 1'b0;
            r_level      <= 1'b0;
            r_pulse      <= 1'b0;
`ifdef DEBOUNCE_REPEAT_EN
            r_rpt_cnt    <= 8'd0;
            r_first      <= 1'b0;
`endif
        end else begin
            r_s1    <= btnIn;
            r_s2    <= r_s1;
            r_pulse <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_timer_ctrl <= 1'b0;
                    if (r_s2) begin
                        r_state      <= WAIT_PRESS;
                        r_timer_ctrl <= 1'b1;
                    end
                end
                WAIT_PRESS: begin
                    // A low sample beats a simultaneous expiry.
                    if (!r_s2) begin
                        r_state      <= IDLE;
                        r_timer_ctrl <= 1'b0;
                    end else if (timerOut) begin
                        r_state      <= HELD;
                        r_timer_ctrl <= 1'b0;
                        r_pulse      <= 1'b1;
                        r_level      <= 1'b1;
`ifdef DEBOUNCE_REPEAT_EN
                        r_rpt_cnt    <= 8'd0;
                        r_first      <= 1'b0;
`endif
                    end
                end
                HELD: begin
                    if (!r_s2) begin
                        r_state      <= WAIT_RELEASE;
                        r_timer_ctrl <= 1'b1;
`ifdef DEBOUNCE_REPEAT_EN
                        r_rpt_cnt    <= 8'd0;
                        r_first      <= 1'b0;
`endif
                    end else begin
`ifdef DEBOUNCE_REPEAT_EN
                        // Dropping enable for one cycle restarts the timer from zero.
                        r_timer_ctrl <= ~w_expiry;
                        if (w_expiry) begin
                            if (w_cnt_next == w_target) begin
                                r_pulse   <= 1'b1;
                                r_rpt_cnt <= 8'd0;
                                r_first   <= 1'b1;
                            end else begin
                                r_rpt_cnt <= w_cnt_next;
                            end
                        end
`else
                        r_timer_ctrl <= 1'b0;
`endif
                    end
                end
                WAIT_RELEASE: begin
                    if (r_s2) begin
                        r_state      <= HELD;
                        r_timer_ctrl <= 1'b0;
                    end else if (timerOut) begin
                        r_state      <= IDLE;
                        r_timer_ctrl <= 1'b0;
                        r_level      <= 1'b0;
                    end
                end
                default: begin
                    r_state      <= IDLE;
                    r_timer_ctrl <= 1'b0;
                end
            endcase
        end
    end

    assign timerControl = r_timer_ctrl;
    assign btnLevel     = r_level;
    assign btnPulse     = r_pulse;

endmodule

// File: tb/tb_button_debounce_fsm.sv
// tb/tb_button_debounce_fsm.sv - randomized bench for button_debounce_fsm against a run-length model
module tb_button_debounce_fsm;

    localparam int N  = 50;
    localparam int P  = N + 1;
    localparam int D  = 63;
    localparam int R  = 13;
    localparam int DE = (D == 0) ? 1 : D;
    localparam int RE = (R == 0) ? 1 : R;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic btnIn = 1'b0;
    logic timerOut;
    logic timerControl;
    logic btnLevel;
    logic btnPulse;

    int tcnt = 0;

    int errors = 0;
    int checks = 0;
    int edges = 0;
    int pulses = 0;
    int pulse_edge = -1;
    int fall_edge = -1;
    int mark = 0;
    logic prev_level = 1'b0;

    logic m_s1 = 1'b0;
    logic m_s2 = 1'b0;
    logic m_level = 1'b0;
    logic m_pulse = 1'b0;
    logic m_tc = 1'b0;
    int   m_run = 0;
    int   m_t = 0;

    always #5 clk = ~clk;

    // Interval timer: held at zero while disabled, flags the last count of each interval.
    always_ff @(posedge clk) begin
        if (rst || !timerControl) tcnt <= 0;
        else tcnt <= (tcnt == N - 1) ? 0 : tcnt + 1;
    end
    assign timerOut = (tcnt == N - 1);

    button_debounce_fsm dut (
        .clk          (clk),
        .rst          (rst),
        .btnIn        (btnIn),
        .timerOut     (timerOut),
        .timerControl (timerControl),
        .btnLevel     (btnLevel),
        .btnPulse     (btnPulse)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at edge %0d: got %0d expected %0d", tag, edges, got, exp);
        end
    endtask

    function automatic bit fires(input int n);
        return (n == DE) || (n > DE && ((n - DE) % RE) == 0);
    endfunction

    // Level flips once the synchronised input has disagreed with it for P consecutive edges.
    task automatic model_edge(input logic b, input logic r);
        logic cur;
        if (r) begin
            m_s1 = 1'b0; m_s2 = 1'b0; m_level = 1'b0; m_pulse = 1'b0;
            m_tc = 1'b0; m_run = 0; m_t = 0;
            return;
        end
        cur = m_s2;
        m_s2 = m_s1;
        m_s1 = b;
        m_pulse = 1'b0;
        if (cur != m_level) begin
            m_run++;
            if (m_run == P) begin
                m_level = ~m_level;
                m_run = 0;
                m_t = 0;
                m_tc = 1'b0;
                m_pulse = m_level;
            end else begin
                m_tc = 1'b1;
            end
        end else begin
            if (m_level && m_run > 0) m_t = 0;
            else if (m_level) m_t++;
            m_run = 0;
            m_tc = 1'b0;
`ifdef DEBOUNCE_REPEAT_EN
            if (m_level) begin
                m_tc = (m_t % P) != 0;
                if (m_t > 0 && (m_t % P) == 0 && fires(m_t / P)) m_pulse = 1'b1;
            end
`endif
        end
    endtask

    task automatic step(input logic b, input logic r);
        @(negedge clk);
        check_val("level", 32'(btnLevel), 32'(m_level));
        check_val("pulse", 32'(btnPulse), 32'(m_pulse));
        check_val("tctl", 32'(timerControl), 32'(m_tc));
        if (btnPulse === 1'b1) begin
            pulses++;
            pulse_edge = edges;
        end
        if (prev_level === 1'b1 && btnLevel === 1'b0) fall_edge = edges;
        prev_level = btnLevel;
        btnIn = b;
        rst = r;
        @(posedge clk);
        edges++;
        model_edge(b, r);
    endtask

    task automatic hold(input logic b, input int n);
        for (int i = 0; i < n; i++) step(b, 1'b0);
    endtask

    initial begin
        @(posedge clk);
        model_edge(1'b0, 1'b1);

        // Reset with the button already high, then press latency from release of reset
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
        mark = edges;
        pulses = 0;
        hold(1'b1, N + 10);
        check_val("press_pulses", pulses, 1);
        check_val("press_latency", pulse_edge - (mark + 1), N + 2);

        // Short release bounce is ignored, clean release after N+2 edges
        hold(1'b0, (N * 3) / 5);
        hold(1'b1, N);
        check_val("rel_bounce_pulses", pulses, 1);
        check_val("rel_bounce_level", 32'(btnLevel), 1);
        mark = edges;
        hold(1'b0, N + 10);
        check_val("release_latency", fall_edge - (mark + 1), N + 2);

        // Press bounce: 20 short toggles then stable high
        pulses = 0;
        pulse_edge = -1;
        for (int i = 0; i < 20; i++)
            hold((i % 2 == 0) ? 1'b1 : 1'b0, int'($urandom_range(N / 4, N - 5)));
        check_val("bounce_early_pulses", pulses, 0);
        mark = edges;
        hold(1'b1, N + 10);
        check_val("bounce_pulses", pulses, 1);
        check_val("bounce_latency", pulse_edge - (mark + 1), N + 2);
        hold(1'b0, N + 10);

        // Single-cycle glitch
        pulses = 0;
        step(1'b1, 1'b0);
        hold(1'b0, N + 10);
        check_val("glitch_pulses", pulses, 0);

        // Reset in the middle of a debounce
        hold(1'b1, N / 2);
        step(1'b1, 1'b1);
        hold(1'b0, N + 10);
        check_val("midrst_pulses", pulses, 0);

        // Random activity with occasional resets
        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(0, 15) == 0) step(1'($urandom_range(0, 1)), 1'b1);
            hold(1'($urandom_range(0, 1)), int'($urandom_range(1, 2 * N)));
        end
        hold(1'b0, N + 10);

        // Long hold: auto-repeat only when the feature is built
        pulses = 0;
        hold(1'b1, (DE + 2 * RE + 2) * P);
`ifdef DEBOUNCE_REPEAT_EN
        check_val("hold_pulses", pulses, 4);
`else
        check_val("hold_pulses", pulses, 1);
`endif
        pulses = 0;
        hold(1'b0, N + 10);
        check_val("post_release_pulses", pulses, 0);
        check_val("final_level", 32'(btnLevel), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
